// File: rtl/wb_pkg.sv
// wb_pkg: shared types and default widths for the write-back arbiter.
package wb_pkg;
  localparam int XLEN_DEF = 64;
  localparam int AW_DEF = 5;
  typedef enum logic {LAST_A, LAST_M} arb_state_t;
  typedef struct packed {
    logic we;
    logic [AW_DEF-1:0] addr;
    logic [XLEN_DEF-1:0] data;
  } wr_port_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: ALU/load write-back requests, register-file write port and forwarding taps.
interface wb_arbiter_if import wb_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int AW = AW_DEF
);
  logic a_valid_i, a_ready_o;
  logic [AW-1:0] a_addr_i;
  logic [XLEN-1:0] a_data_i;
  logic m_valid_i, m_ready_o;
  logic [AW-1:0] m_addr_i;
  logic [XLEN-1:0] m_data_i;
  logic RegWrite_o;
  logic [AW-1:0] wAddr_o;
  logic [XLEN-1:0] wData_o;
  logic [AW-1:0] rAddr01_i, rAddr02_i;
  logic fwd01_o, fwd02_o;
  modport slave (
    input a_valid_i, a_addr_i, a_data_i, m_valid_i, m_addr_i, m_data_i, rAddr01_i, rAddr02_i,
    output a_ready_o, m_ready_o, RegWrite_o, wAddr_o, wData_o, fwd01_o, fwd02_o
  );
  modport master (
    output a_valid_i, a_addr_i, a_data_i, m_valid_i, m_addr_i, m_data_i, rAddr01_i, rAddr02_i,
    input a_ready_o, m_ready_o, RegWrite_o, wAddr_o, wData_o, fwd01_o, fwd02_o
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; grant[0]=A, grant[1]=M.
module rr_arb2 import wb_pkg::*; (
  input logic a_valid,
  input logic m_valid,
  input arb_state_t state,
  output logic [1:0] grant
);
  assign grant[0] = a_valid & (!m_valid | state == LAST_M);
  assign grant[1] = m_valid & (!a_valid | state == LAST_A);
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates ALU and load write-backs onto one register-file write port; WB_ARB_STATS_EN adds conflict_cnt_o.
module wb_arbiter import wb_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int AW = AW_DEF
) (
  input logic clk,
  input logic rst_n,
  wb_arbiter_if.slave bus
`ifdef WB_ARB_STATS_EN
  , output logic [15:0] conflict_cnt_o
`endif
);
  arb_state_t state;
  logic [1:0] grant;
  logic acc_a, acc_m;
  logic [AW-1:0] sel_addr;
  logic [XLEN-1:0] sel_data;
  rr_arb2 u_rr (.a_valid(bus.a_valid_i), .m_valid(bus.m_valid_i), .state(state), .grant(grant));
  // readies are gated by rst_n so nothing can be accepted while reset is held
  assign bus.a_ready_o = rst_n & grant[0];
  assign bus.m_ready_o = rst_n & grant[1];
  assign acc_a = bus.a_valid_i & bus.a_ready_o;
  assign acc_m = bus.m_valid_i & bus.m_ready_o;
  always_comb begin
    sel_addr = acc_a ? bus.a_addr_i : bus.m_addr_i;
    sel_data = acc_a ? bus.a_data_i : bus.m_data_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.RegWrite_o <= 1'b0;
      bus.wAddr_o <= '0;
      bus.wData_o <= '0;
      state <= LAST_M;
    end else begin
      bus.RegWrite_o <= (acc_a | acc_m) && sel_addr != '0;
      if (acc_a | acc_m) begin
        bus.wAddr_o <= sel_addr;
        bus.wData_o <= sel_data;
        state <= acc_a ? LAST_A : LAST_M;
      end
    end
  end
  assign bus.fwd01_o = bus.RegWrite_o && bus.wAddr_o == bus.rAddr01_i && bus.rAddr01_i != '0;
  assign bus.fwd02_o = bus.RegWrite_o && bus.wAddr_o == bus.rAddr02_i && bus.rAddr02_i != '0;
`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_cnt_o <= '0;
    else if (bus.a_valid_i && bus.m_valid_i && conflict_cnt_o != 16'hFFFF) conflict_cnt_o <= conflict_cnt_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table plus reset/contention sequences for wb_arbiter.
module tb_wb_arbiter;
  import wb_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;
  wb_arbiter_if #(.XLEN(64), .AW(5)) bus ();
`ifdef WB_ARB_STATS_EN
  logic [15:0] conflict_cnt_o;
  wb_arbiter #(.XLEN(64), .AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .conflict_cnt_o(conflict_cnt_o));
`else
  wb_arbiter #(.XLEN(64), .AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [4:0] aa; logic [63:0] ad;
    logic mv; logic [4:0] ma; logic [63:0] md;
    logic [4:0] r1; logic [4:0] r2;
    logic ear; logic emr;
    wr_port_t ew; logic chk_w;
    logic ef1; logic ef2;
  } vec_t;
  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [63:0] md,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.a_valid_i = av; bus.a_addr_i = aa; bus.a_data_i = ad;
    bus.m_valid_i = mv; bus.m_addr_i = ma; bus.m_data_i = md;
    bus.rAddr01_i = r1; bus.rAddr02_i = r2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // av aa ad          mv ma md        r1 r2 ear emr  {we,addr,data}     chk f1 f2
    vecs[0]  = '{1, 3, 64'h11, 0, 0, 64'h0,  3, 3, 1, 0, '{1'b1, 5'd3, 64'h11}, 1, 1, 1};
    vecs[1]  = '{0, 0, 64'h0,  0, 0, 64'h0,  3, 0, 0, 0, '{1'b0, 5'd3, 64'h11}, 1, 0, 0};
    vecs[2]  = '{1, 1, 64'hA1, 1, 2, 64'hB2, 1, 2, 0, 1, '{1'b1, 5'd2, 64'hB2}, 1, 0, 1};
    vecs[3]  = '{1, 1, 64'hA1, 1, 2, 64'hB2, 1, 2, 1, 0, '{1'b1, 5'd1, 64'hA1}, 1, 1, 0};
    vecs[4]  = '{0, 0, 64'h0,  1, 7, 64'h77, 7, 0, 0, 1, '{1'b1, 5'd7, 64'h77}, 1, 1, 0};
    vecs[5]  = '{1, 0, 64'h99, 0, 0, 64'h0,  0, 0, 1, 0, '{1'b0, 5'd0, 64'h0},  0, 0, 0};
    vecs[6]  = '{1, 4, 64'h44, 1, 5, 64'h55, 5, 4, 0, 1, '{1'b1, 5'd5, 64'h55}, 1, 1, 0};
    vecs[7]  = '{0, 0, 64'h0,  1, 0, 64'h66, 5, 5, 0, 1, '{1'b0, 5'd0, 64'h0},  0, 0, 0};
    vecs[8]  = '{1, 4, 64'h44, 1, 5, 64'h55, 4, 4, 1, 0, '{1'b1, 5'd4, 64'h44}, 1, 1, 1};
    vecs[9]  = '{0, 0, 64'h0,  1, 0, 64'h66, 4, 4, 0, 1, '{1'b0, 5'd0, 64'h0},  0, 0, 0};
    vecs[10] = '{1, 4, 64'h44, 1, 5, 64'h55, 0, 4, 1, 0, '{1'b1, 5'd4, 64'h44}, 1, 0, 1};

    rst_n = 1'b0;
    drive(1, 1, 64'h10, 1, 2, 64'h20, 0, 0);
    repeat (2) step();
    chk("rst regwrite", bus.RegWrite_o, 0);
    chk("rst waddr", bus.wAddr_o, 0);
    chk("rst wdata", bus.wData_o, 0);
    chk("rst a_ready", bus.a_ready_o, 0);
    chk("rst m_ready", bus.m_ready_o, 0);
`ifdef WB_ARB_STATS_EN
    chk("rst conflict_cnt", conflict_cnt_o, 0);
`endif

    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d a_ready", k), bus.a_ready_o, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d m_ready", k), bus.m_ready_o, (k % 2 == 1) ? 1 : 0);
      step();
      chk($sformatf("rr%0d regwrite", k), bus.RegWrite_o, 1);
      chk($sformatf("rr%0d waddr", k), bus.wAddr_o, (k % 2 == 0) ? 1 : 2);
      chk($sformatf("rr%0d wdata", k), bus.wData_o, (k % 2 == 0) ? 64'h10 : 64'h20);
    end
`ifdef WB_ARB_STATS_EN
    chk("rr conflict_cnt", conflict_cnt_o, 4);
`endif

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md, vecs[i].r1, vecs[i].r2);
      #1;
      chk($sformatf("v%0d a_ready", i), bus.a_ready_o, vecs[i].ear);
      chk($sformatf("v%0d m_ready", i), bus.m_ready_o, vecs[i].emr);
      step();
      chk($sformatf("v%0d regwrite", i), bus.RegWrite_o, vecs[i].ew.we);
      if (vecs[i].chk_w) begin
        chk($sformatf("v%0d waddr", i), bus.wAddr_o, vecs[i].ew.addr);
        chk($sformatf("v%0d wdata", i), bus.wData_o, vecs[i].ew.data);
      end
      chk($sformatf("v%0d fwd01", i), bus.fwd01_o, vecs[i].ef1);
      chk($sformatf("v%0d fwd02", i), bus.fwd02_o, vecs[i].ef2);
    end

    drive(1, 1, 64'h10, 1, 2, 64'h20, 1, 2);
    step();
    chk("mid m first", bus.wAddr_o, 2);
    step();
    chk("mid a second", bus.wAddr_o, 1);
    chk("mid regwrite pre", bus.RegWrite_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async regwrite", bus.RegWrite_o, 0);
    chk("async waddr", bus.wAddr_o, 0);
    chk("async wdata", bus.wData_o, 0);
    chk("async a_ready", bus.a_ready_o, 0);
    chk("async m_ready", bus.m_ready_o, 0);
    chk("async fwd01", bus.fwd01_o, 0);
`ifdef WB_ARB_STATS_EN
    chk("async conflict_cnt", conflict_cnt_o, 0);
`endif
    step();
    rst_n = 1'b1;
    #1;
    chk("post a_ready", bus.a_ready_o, 1);
    chk("post m_ready", bus.m_ready_o, 0);
    step();
    chk("post regwrite", bus.RegWrite_o, 1);
    chk("post waddr", bus.wAddr_o, 1);
    chk("post wdata", bus.wData_o, 64'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
